// File: rtl/tl_pkg.sv
// Shared traffic-light encodings: vehicle lamp bus and pedestrian stage states.
package tl_pkg;

    localparam int unsigned RGB_W       = 3;
    localparam int unsigned PED_STATE_W = 2;

    // One-hot vehicle lamp encodings, shared with the controller
    localparam logic [RGB_W-1:0] RGB_R = 3'b100;
    localparam logic [RGB_W-1:0] RGB_G = 3'b010;
    localparam logic [RGB_W-1:0] RGB_Y = 3'b001;

    // Pedestrian stage states (also the ped_state output encoding)
    localparam logic [PED_STATE_W-1:0] PED_IDLE  = 2'd0;
    localparam logic [PED_STATE_W-1:0] PED_WALK  = 2'd1;
    localparam logic [PED_STATE_W-1:0] PED_FLASH = 2'd2;

    // True when exactly one vehicle lamp is lit
    function automatic logic rgb_legal(input logic [RGB_W-1:0] lamps);
        return $onehot(lamps);
    endfunction

endpackage

// File: rtl/tl_ped_timer.sv
// Loadable down counter for the pedestrian phase countdown.
// Load wins over decrement; decrement stops at zero so the count never wraps.
// zero is registered alongside count and always equals (count == 0).
module tl_ped_timer
    import tl_pkg::*;
#(
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          zero
);

    logic [CW-1:0] count_n;

    // Next count: load has priority, decrement only while nonzero
    always_comb begin
        count_n = count;
        if (load) begin
            count_n = load_val;
        end else if (dec && (count != '0)) begin
            count_n = count - CW'(1);
        end
    end

    // Count register with matching zero flag
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            zero  <= 1'b1;
        end else begin
            count <= count_n;
            zero  <= (count_n == '0);
        end
    end

endmodule

// File: rtl/tl_ped_crossing.sv
// Pedestrian signal stage fed by the vehicle lamp bus.
// WALK is granted only on RED and revoked the cycle RED is lost.
// Optional macro PED_FAULT_EN: non-one-hot rgb sets a sticky fault that forces
// IDLE and blocks grants until reset. Without it, fault stays 0.
module tl_ped_crossing
    import tl_pkg::*;
#(
    parameter int unsigned WALK_CYC  = 8,
    parameter int unsigned FLASH_CYC = 4,
    parameter int unsigned BLINK_DIV = 1,
    parameter int unsigned CW        = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RGB_W-1:0]       rgb,
    input  logic                   ped_btn,
    output logic                   walk,
    output logic                   dont_walk,
    output logic [CW-1:0]          countdown,
    output logic                   req_pending,
    output logic [PED_STATE_W-1:0] ped_state,
    output logic                   fault
);

    localparam int unsigned     BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0]   WALK_LOAD  = CW'(WALK_CYC - 1);
    localparam logic [CW-1:0]   FLASH_LOAD = CW'(FLASH_CYC - 1);
    localparam logic [BW-1:0]   BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [PED_STATE_W-1:0] state, state_n;
    logic                   btn_q;
    logic                   req_n;
    logic                   fault_n;
    logic                   blink, blink_n;
    logic [BW-1:0]          bcnt, bcnt_n;
    logic                   walk_n, dont_walk_n;
    logic                   btn_rise;
    logic                   is_red;
    logic                   hold_off;
    logic                   tmr_load;
    logic [CW-1:0]          tmr_val;
    logic                   tmr_dec;
    logic                   tmr_zero;

    // Phase countdown
    tl_ped_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .count    (countdown),
        .zero     (tmr_zero)
    );

    // Next state, request latch, blink phase, timer controls and lamp decode
    always_comb begin
        state_n     = state;
        req_n       = req_pending;
        fault_n     = fault;
        blink_n     = 1'b1;
        bcnt_n      = '0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        tmr_dec     = 1'b0;
        walk_n      = 1'b0;
        dont_walk_n = 1'b1;
        btn_rise    = ped_btn & ~btn_q;
        is_red      = (rgb == RGB_R);
        hold_off    = 1'b0;

`ifdef PED_FAULT_EN
        fault_n  = fault | ~rgb_legal(rgb);
        hold_off = fault_n;
`endif

        case (state)
            PED_IDLE: begin
                if (btn_rise) begin
                    req_n = 1'b1;
                end
                // Grant clears the request, absorbing any same-cycle edge
                if (req_pending && is_red && !hold_off) begin
                    state_n  = PED_WALK;
                    req_n    = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = WALK_LOAD;
                end
            end
            PED_WALK: begin
                // Losing red aborts before expiry; service was not completed
                if (!is_red) begin
                    state_n  = PED_IDLE;
                    req_n    = 1'b1;
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_n  = PED_FLASH;
                    tmr_load = 1'b1;
                    tmr_val  = FLASH_LOAD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            PED_FLASH: begin
                if (btn_rise) begin
                    req_n = 1'b1;
                end
                if (!is_red || tmr_zero) begin
                    state_n  = PED_IDLE;
                    tmr_load = 1'b1;
                end else begin
                    tmr_dec = 1'b1;
                    if (bcnt == BLINK_LAST) begin
                        blink_n = ~blink;
                        bcnt_n  = '0;
                    end else begin
                        blink_n = blink;
                        bcnt_n  = bcnt + BW'(1);
                    end
                end
            end
            default: begin
                state_n  = PED_IDLE;
                tmr_load = 1'b1;
            end
        endcase

        walk_n = (state_n == PED_WALK);
        if (state_n == PED_WALK) begin
            dont_walk_n = 1'b0;
        end else if (state_n == PED_FLASH) begin
            dont_walk_n = blink_n;
        end
    end

    // State, request, fault, blink and lamp registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= PED_IDLE;
            btn_q       <= 1'b0;
            req_pending <= 1'b0;
            fault       <= 1'b0;
            blink       <= 1'b1;
            bcnt        <= '0;
            walk        <= 1'b0;
            dont_walk   <= 1'b1;
        end else begin
            state       <= state_n;
            btn_q       <= ped_btn;
            req_pending <= req_n;
            fault       <= fault_n;
            blink       <= blink_n;
            bcnt        <= bcnt_n;
            walk        <= walk_n;
            dont_walk   <= dont_walk_n;
        end
    end

    assign ped_state = state;

endmodule
